calc_control_unit: RTL and testbench

Operation sequencer for the Pocket Calculator Processor: the consumer of the `control_unit_en` strobe produced by the enable flip-flop. When enabled, it latches the opcode and operands, issues one request to the ALU over a req/ack handshake, captures the result or error, and raises `done`. `done` drives the flip-flop's `en` input, which withdraws `control_unit_en` and closes a four-phase loop. It sits between the keypad/operand registers and the ALU.

---
 rtl/calc_control_unit.sv | 96 +++++++++
 tb/tb_calc_control_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_control_unit.sv
// calc_control_unit: sequences one ALU operation per start request.
// Ports: clk, rst (async active-low), control_unit_en, opcode, operand_a,
//   operand_b in; alu_req/op/a/b out; alu_ack/result/err in;
//   result, error, result_valid, busy, done out.
module calc_control_unit #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             control_unit_en,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             alu_req,
   output logic [1:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic             alu_ack,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_err,
   output logic [WIDTH-1:0] result,
   output logic             error,
   output logic             result_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         alu_req      <= 1'b0;
         alu_op       <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         result       <= '0;
         error        <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (control_unit_en) begin
                  alu_op  <= opcode;
                  alu_a   <= operand_a;
                  alu_b   <= operand_b;
                  alu_req <= 1'b1;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               // ack has priority over a timeout on the same edge
               if (alu_ack) begin
                  result       <= alu_result;
                  error        <= alu_err;
                  result_valid <= 1'b1;
                  alu_req      <= 1'b0;
                  done         <= 1'b1;
                  state        <= DONE;
               end else if (cnt == LAST) begin
                  result       <= '0;
                  error        <= 1'b1;
                  result_valid <= 1'b1;
                  alu_req      <= 1'b0;
                  done         <= 1'b1;
                  state        <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               result_valid <= 1'b0;
               if (!control_unit_en) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_control_unit.sv
// tb_calc_control_unit: table-driven and randomized checks of the
// operation sequencer against a transaction-level expectation.
module tb_calc_control_unit;

   localparam int W  = 8;
   localparam int TO = 15;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         control_unit_en = 1'b0;
   logic [1:0]   opcode = '0;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         alu_ack = 1'b0;
   logic [W-1:0] alu_result = '0;
   logic         alu_err = 1'b0;
   logic         alu_req;
   logic [1:0]   alu_op;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] result;
   logic         error;
   logic         result_valid;
   logic         busy;
   logic         done;

   calc_control_unit #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .control_unit_en (control_unit_en),
      .opcode          (opcode),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .alu_req         (alu_req),
      .alu_op          (alu_op),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_ack         (alu_ack),
      .alu_result      (alu_result),
      .alu_err         (alu_err),
      .result          (result),
      .error           (error),
      .result_valid    (result_valid),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           dly;
      logic [W-1:0] r;
      logic         e;
      bit           early;
      int           hold;
      logic [W-1:0] xres;
      logic         xerr;
      int           xn;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Transaction view: an ack arriving on request cycle dly (1..TO)
   // completes with the ALU value; anything later is a timeout at TO.
   function automatic vec_t model(input vec_t v);
      vec_t o = v;
      if (v.dly >= 1 && v.dly <= TO) begin
         o.xres = v.r;
         o.xerr = v.e;
         o.xn   = v.dly;
      end else begin
         o.xres = '0;
         o.xerr = 1'b1;
         o.xn   = TO;
      end
      return o;
   endfunction

   function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int dly,
                               input logic [W-1:0] r, input logic e,
                               input bit early, input int hold,
                               input logic [W-1:0] xres, input logic xerr,
                               input int xn);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.dly = dly; v.r = r; v.e = e;
      v.early = early; v.hold = hold;
      v.xres = xres; v.xerr = xerr; v.xn = xn;
      return v;
   endfunction

   // Call at #1 after a posedge with the unit idle and en low.
   task automatic run_op(input vec_t v, input string nm);
      int n;
      bit late;
      opcode          = v.op;
      operand_a       = v.a;
      operand_b       = v.b;
      control_unit_en = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_req"}, alu_req, 1);
      chk({nm, "_op"}, alu_op, v.op);
      chk({nm, "_a"}, alu_a, v.a);
      chk({nm, "_b"}, alu_b, v.b);
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_done0"}, done, 0);
      operand_a = ~v.a;
      operand_b = ~v.b;
      opcode    = ~v.op;
      if (v.early) control_unit_en = 1'b0;
      n = 0;
      while (alu_req === 1'b1 && n < 4 * TO) begin
         alu_ack    = (n + 1 == v.dly);
         alu_result = alu_ack ? v.r : W'($urandom);
         alu_err    = alu_ack ? v.e : 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_reqcyc"}, n, v.xn);
      chk({nm, "_astable"}, alu_a, v.a);
      chk({nm, "_bstable"}, alu_b, v.b);
      chk({nm, "_res"}, result, v.xres);
      chk({nm, "_err"}, error, v.xerr);
      chk({nm, "_rv1"}, result_valid, 1);
      chk({nm, "_done1"}, done, 1);
      chk({nm, "_busy1"}, busy, 1);
      late       = (v.dly > TO);
      alu_ack    = late;
      alu_result = 8'h77;
      alu_err    = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_rv0"}, result_valid, 0);
      chk({nm, "_reqoff"}, alu_req, 0);
      chk({nm, "_reshold"}, result, v.xres);
      if (v.early) begin
         chk({nm, "_done_1cyc"}, done, 0);
         chk({nm, "_busy_off"}, busy, 0);
      end else begin
         chk({nm, "_done_hold"}, done, 1);
         repeat (v.hold) begin
            @(posedge clk); #1;
            chk({nm, "_done_hold"}, done, 1);
         end
         control_unit_en = 1'b0;
         @(posedge clk); #1;
         chk({nm, "_done_off"}, done, 0);
         chk({nm, "_busy_off"}, busy, 0);
      end
      if (late) begin
         @(posedge clk); #1;
         chk({nm, "_late_req"}, alu_req, 0);
         chk({nm, "_late_res"}, result, 0);
         chk({nm, "_late_err"}, error, 1);
      end
      alu_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      vec_t v;
      tbl[0] = mk(2'd0, 8'd5, 8'd3, 2, 8'h08, 1'b0, 0, 0, 8'h08, 1'b0, 2);
      tbl[1] = mk(2'd3, 8'd7, 8'd0, 1, 8'hFF, 1'b1, 0, 1, 8'hFF, 1'b1, 1);
      tbl[2] = mk(2'd0, 8'd1, 8'd2, 99, 8'h00, 1'b0, 0, 0, 8'h00, 1'b1, 15);
      tbl[3] = mk(2'd0, 8'd1, 8'd1, 15, 8'h2A, 1'b0, 0, 0, 8'h2A, 1'b0, 15);
      tbl[4] = mk(2'd1, 8'd3, 8'd5, 1, 8'hFE, 1'b0, 0, 0, 8'hFE, 1'b0, 1);
      tbl[5] = mk(2'd2, 8'd4, 8'd6, 3, 8'h18, 1'b0, 0, 0, 8'h18, 1'b0, 3);
      tbl[6] = mk(2'd0, 8'd9, 8'd9, 3, 8'h11, 1'b0, 1, 0, 8'h11, 1'b0, 3);
      tbl[7] = mk(2'd1, 8'd0, 8'd0, 16, 8'h33, 1'b0, 0, 0, 8'h00, 1'b1, 15);

      #12;
      chk("rst_req", alu_req, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res", result, 0);
      chk("rst_err", error, 0);
      chk("rst_rv", result_valid, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_req", alu_req, 0);

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i));
      end

      opcode          = 2'd2;
      operand_a       = 8'd9;
      operand_b       = 8'd9;
      control_unit_en = 1'b1;
      @(posedge clk); #1;
      chk("mid_req", alu_req, 1);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("mid_rst_req", alu_req, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_a", alu_a, 0);
      chk("mid_rst_res", result, 0);
      control_unit_en = 1'b0;
      alu_ack         = 1'b1;
      alu_result      = 8'h55;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_req", alu_req, 0);
      chk("post_rst_res", result, 0);
      chk("post_rst_rv", result_valid, 0);
      alu_ack = 1'b0;
      run_op(mk(2'd0, 8'd2, 8'd2, 2, 8'h04, 1'b0, 0, 0, 8'h04, 1'b0, 2),
             "after_rst");

      for (int i = 0; i < 24; i++) begin
         v.op    = 2'($urandom);
         v.a     = W'($urandom);
         v.b     = W'($urandom);
         v.dly   = $urandom_range(1, TO + 3);
         v.r     = W'($urandom);
         v.e     = 1'($urandom);
         v.early = ($urandom_range(0, 3) == 0);
         v.hold  = $urandom_range(0, 2);
         run_op(model(v), $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
